// File: rtl/mips_defs.sv
// ============================================================================
// Module : mips_defs (package)
// Brief  : Opcode/funct encodings, Tuse/Tnew constants and the decoded
//          instruction record shared by the hazard controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2a;
    localparam logic [5:0] FN_SLTU    = 6'h2b;

    // TUSE_NONE exceeds every Tnew, so an unread source can never stall
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_0    = 2'd0;
    localparam logic [1:0] TNEW_1    = 2'd1;
    localparam logic [1:0] TNEW_2    = 2'd2;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [3:0] {
        IC_OTHER  = 4'd0,
        IC_CAL_R  = 4'd1,
        IC_CAL_I  = 4'd2,
        IC_LOAD   = 4'd3,
        IC_STORE  = 4'd4,
        IC_BRANCH = 4'd5,
        IC_JR     = 4'd6,
        IC_JAL    = 4'd7,
        IC_MD     = 4'd8,
        IC_HILO   = 4'd9
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [1:0] tnew_e;
        logic [1:0] tnew_m;
    } hinfo_t;

endpackage

`default_nettype wire

// File: rtl/hctrl.sv
// ============================================================================
// Module : hctrl
// Brief  : Instruction classifier with Tuse/Tnew and destination lookup,
//          instanced once per pipeline stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hctrl
    import mips_defs::*;
(
    input  logic [31:0] instr_i,
    output hinfo_t      info_o
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    iclass_e    w_cls;
    logic [4:0] w_dest;
    logic       unused_shamt;

    assign w_op         = instr_i[31:26];
    assign w_fn         = instr_i[5:0];
    assign unused_shamt = ^instr_i[10:6];

    function automatic logic [1:0] tuse_rs_of(input iclass_e c);
        case (c)
            IC_BRANCH, IC_JR:                       return TUSE_0;
            IC_CAL_R, IC_CAL_I, IC_LOAD, IC_STORE:  return TUSE_1;
            default:                                return TUSE_NONE;
        endcase
    endfunction

    function automatic logic [1:0] tuse_rt_of(input iclass_e c);
        case (c)
            IC_BRANCH: return TUSE_0;
            IC_CAL_R:  return TUSE_1;
            IC_STORE:  return TUSE_2;
            default:   return TUSE_NONE;
        endcase
    endfunction

    function automatic logic [1:0] tnew_e_of(input iclass_e c);
        case (c)
            IC_CAL_R, IC_CAL_I, IC_JAL: return TNEW_1;
            IC_LOAD:                    return TNEW_2;
            default:                    return TNEW_0;
        endcase
    endfunction

    function automatic logic [1:0] tnew_m_of(input iclass_e c);
        return (c == IC_LOAD) ? TNEW_1 : TNEW_0;
    endfunction

    always_comb begin
        w_cls = IC_OTHER;
        case (w_op)
            OP_SPECIAL: begin
                case (w_fn)
                    FN_JR:                                  w_cls = IC_JR;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:     w_cls = IC_MD;
                    FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO:     w_cls = IC_HILO;
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU:                        w_cls = IC_CAL_R;
                    default:                                w_cls = IC_OTHER;
                endcase
            end
            OP_JAL:                                 w_cls = IC_JAL;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:       w_cls = IC_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:       w_cls = IC_CAL_I;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:    w_cls = IC_LOAD;
            OP_SB, OP_SH, OP_SW:                    w_cls = IC_STORE;
            default:                                w_cls = IC_OTHER;
        endcase
    end

    always_comb begin
        case (w_cls)
            IC_CAL_R:          w_dest = instr_i[15:11];
            IC_CAL_I, IC_LOAD: w_dest = instr_i[20:16];
            IC_JAL:            w_dest = REG_RA;
            default:           w_dest = 5'd0;
        endcase
    end

    assign info_o.cls     = w_cls;
    assign info_o.rs      = instr_i[25:21];
    assign info_o.rt      = instr_i[20:16];
    assign info_o.dest    = w_dest;
    assign info_o.tuse_rs = tuse_rs_of(w_cls);
    assign info_o.tuse_rt = tuse_rt_of(w_cls);
    assign info_o.tnew_e  = tnew_e_of(w_cls);
    assign info_o.tnew_m  = tnew_m_of(w_cls);

endmodule

`default_nettype wire

// File: rtl/stall_ctrl.sv
// ============================================================================
// Module : stall_ctrl
// Brief  : D-stage hazard controller: Tuse/Tnew data stalls plus mult/div busy
//          window. Optional stall-cycle counter built when STALL_CNT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_ctrl
    import mips_defs::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrD,
    input  logic [31:0] instrE,
    input  logic [31:0] instrM,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_clr,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    localparam int CNT_W = $clog2(DIV_LAT);

    hinfo_t           d_info;
    hinfo_t           e_info;
    hinfo_t           m_info;
    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] md_cnt_d;
    logic             w_md_start;
    logic             w_e_is_div;
    logic             w_md_busy;
    logic             w_stall_data;
    logic             w_stall_md;
    logic             w_stall;
    logic             unused_info;

    hctrl u_hctrl_d (.instr_i(instrD), .info_o(d_info));
    hctrl u_hctrl_e (.instr_i(instrE), .info_o(e_info));
    hctrl u_hctrl_m (.instr_i(instrM), .info_o(m_info));

    assign unused_info = ^{d_info.dest, d_info.tnew_e, d_info.tnew_m,
                           e_info.rs, e_info.rt, e_info.tuse_rs, e_info.tuse_rt, e_info.tnew_m,
                           m_info.cls, m_info.rs, m_info.rt, m_info.tuse_rs, m_info.tuse_rt,
                           m_info.tnew_e};

    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input hinfo_t e, input hinfo_t m);
        return (src != 5'd0) &&
               (((src == e.dest) && (tuse < e.tnew_e)) ||
                ((src == m.dest) && (tuse < m.tnew_m)));
    endfunction

    assign w_stall_data = src_hazard(d_info.rs, d_info.tuse_rs, e_info, m_info) |
                          src_hazard(d_info.rt, d_info.tuse_rt, e_info, m_info);

    assign w_md_start = (e_info.cls == IC_MD);
    assign w_e_is_div = (instrE[5:0] == FN_DIV) || (instrE[5:0] == FN_DIVU);
    assign w_md_busy  = w_md_start | (md_cnt_q != '0);
    assign w_stall_md = w_md_busy & ((d_info.cls == IC_MD) || (d_info.cls == IC_HILO));

    // Reset overrides every hold/bubble request in the same cycle
    assign w_stall  = ~reset & (w_stall_data | w_stall_md);
    assign pc_en    = ~w_stall;
    assign ifid_en  = ~w_stall;
    assign idex_clr = w_stall;
    assign md_busy  = ~reset & w_md_busy;

    // A fresh start reloads even if the window is still open
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (w_md_start) begin
            md_cnt_d = w_e_is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
        end else if (w_stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire
